seq_mag_comparator: RTL and testbench

- Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands.
- Compares CHUNK bits per cycle, most-significant chunk first, and terminates early at the first differing chunk.
- Reports mutually exclusive eq / lt / gt results, with an optional two's-complement (signed) mode.
- Sits in the datapath where a wide compare must not sit in a single-cycle critical path; a start/busy/done handshake connects it to a controlling FSM.

---
 rtl/seq_mag_comparator.sv | 120 ++++++++++++
 tb/tb_seq_mag_comparator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator, CHUNK bits per cycle, MS chunk first.
// Early exit on first differing chunk; optional two's-complement mode.
module seq_mag_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_param
    $error("WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sm_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             eq_q;
  logic             lt_q;
  logic             gt_q;

  logic [CHUNK-1:0] ca_d;
  logic [CHUNK-1:0] cb_d;
  logic             c_lt_d;
  logic             c_gt_d;
  logic             last_d;

  // Top chunk compare; sign bits flipped on chunk 0 for signed mode
  always_comb begin
    ca_d = a_q[WIDTH-1 -: CHUNK];
    cb_d = b_q[WIDTH-1 -: CHUNK];
    if (sm_q && cnt_q == '0) begin
      ca_d[CHUNK-1] = ~ca_d[CHUNK-1];
      cb_d[CHUNK-1] = ~cb_d[CHUNK-1];
    end
    c_lt_d = ca_d < cb_d;
    c_gt_d = ca_d > cb_d;
    last_d = cnt_q == LAST;
  end

  // Control FSM with operand shifting and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            sm_q    <= signed_mode;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (c_lt_d || c_gt_d) begin
            eq_q    <= 1'b0;
            lt_q    <= c_lt_d;
            gt_q    <= c_gt_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (last_d) begin
            eq_q    <= 1'b1;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            a_q   <= a_q << CHUNK;
            b_q   <= b_q << CHUNK;
            cnt_q <= cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
  assign lt   = lt_q;
  assign gt   = gt_q;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Bench for seq_mag_comparator: directed cases plus random traffic
// checked every cycle against an arithmetic reference model.
module tb_seq_mag_comparator;

  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, eq, lt, gt;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_mag_comparator #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .signed_mode(signed_mode),
    .busy(busy), .done(done), .eq(eq), .lt(lt), .gt(gt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // j = first differing chunk (N-1 if equal); r = {eq,lt,gt}
  function automatic void ref_cmp(input logic [W-1:0] x,
                                  input logic [W-1:0] y,
                                  input logic s,
                                  output int j,
                                  output logic [2:0] r);
    logic [W-1:0] xs, ys;
    bit found;
    j = N - 1;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      xs = x >> ((N - 1 - k) * C);
      ys = y >> ((N - 1 - k) * C);
      if (!found && xs[C-1:0] != ys[C-1:0]) begin
        j = k;
        found = 1'b1;
      end
    end
    if (x == y) r = 3'b100;
    else if (s ? ($signed(x) < $signed(y)) : (x < y)) r = 3'b010;
    else r = 3'b001;
  endfunction

  // Reference model: countdown to the done cycle
  logic       m_busy, m_done;
  logic [2:0] m_res, m_pend;
  int         m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= 3'b000;
      m_pend <= 3'b000;
      m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      m_busy <= (m_left != 1);
      if (m_left == 1) m_res <= m_pend;
    end else begin
      m_done <= 1'b0;
      if (start) begin : acc
        int jj;
        logic [2:0] rr;
        ref_cmp(a, b, signed_mode, jj, rr);
        m_left <= jj + 1;
        m_busy <= 1'b1;
        m_pend <= rr;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      chk("cycle", {27'd0, busy, done, eq, lt, gt},
          {27'd0, m_busy, m_done, m_res});
  end

  task automatic run_cmp(input string nm, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic s,
                         input int exp_cyc, input logic [2:0] exp_r);
    int k, nb;
    @(negedge clk);
    a = x; b = y; signed_mode = s; start = 1'b1;
    k = 0; nb = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      k++;
      if (busy) nb++;
    end while (!done && k < 20);
    chk({nm, " done cycle"}, k, exp_cyc);
    chk({nm, " busy cycles"}, nb, exp_cyc - 1);
    chk({nm, " result"}, {29'd0, eq, lt, gt}, {29'd0, exp_r});
  endtask

  initial begin
    int j, k, nd, dc, bad;
    logic [2:0] r;
    logic [W-1:0] rnd, msk;

    ref_cmp(16'h1234, 16'h1234, 1'b0, j, r);
    chk("ref eq j", j, 3);
    chk("ref eq r", r, 3'b100);
    ref_cmp(16'h8000, 16'h7FFF, 1'b1, j, r);
    chk("ref sgn j", j, 0);
    chk("ref sgn r", r, 3'b010);
    ref_cmp(16'h8000, 16'h7FFF, 1'b0, j, r);
    chk("ref uns r", r, 3'b001);
    ref_cmp(16'hFFFE, 16'hFFFF, 1'b1, j, r);
    chk("ref neg j", j, 3);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("reset outs", {27'd0, busy, done, eq, lt, gt}, 0);

    run_cmp("equal", 16'h1234, 16'h1234, 1'b0, 5, 3'b100);
    run_cmp("uns msb", 16'h8000, 16'h7FFF, 1'b0, 2, 3'b001);
    run_cmp("sgn msb", 16'h8000, 16'h7FFF, 1'b1, 2, 3'b010);
    run_cmp("last chunk", 16'h1235, 16'h1234, 1'b0, 5, 3'b001);
    run_cmp("sgn neg", 16'hFFFE, 16'hFFFF, 1'b1, 5, 3'b010);

    // start held high while busy; operands change after capture
    @(negedge clk);
    a = 16'h00F0; b = 16'h00F1; signed_mode = 1'b0; start = 1'b1;
    nd = 0; dc = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin a = 16'hFFFF; b = 16'h0000; end
      if (done) begin nd++; dc = c; end
    end
    chk("ign start dones", nd, 1);
    chk("ign start cycle", dc, 5);
    chk("ign start res", {29'd0, eq, lt, gt}, 3'b010);
    @(negedge clk);
    start = 1'b0;
    chk("restart busy", {31'd0, busy}, 1);
    chk("restart held", {29'd0, eq, lt, gt}, 3'b010);
    @(negedge clk);
    chk("restart done", {30'd0, done, gt}, 2'b11);

    // async reset mid-compare
    @(negedge clk);
    a = 16'h1234; b = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("async rst", {27'd0, busy, done, eq, lt, gt}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no done after rst", nd, 0);
    run_cmp("after rst", 16'h1234, 16'h1234, 1'b0, 5, 3'b100);

    // back-to-back: start accepted in the done cycle
    @(negedge clk);
    a = 16'h4000; b = 16'h3000; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("b2b first", {30'd0, done, gt}, 2'b11);
    a = 16'h0001; b = 16'h0002; start = 1'b1;
    bad = 0;
    for (int c = 3; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done || !gt || lt || eq) bad++;
    end
    chk("b2b held", bad, 0);
    @(negedge clk);
    chk("b2b second", {29'd0, done, lt, gt}, 3'b110);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      signed_mode = $urandom_range(0, 1) == 1;
      a = W'($urandom);
      rnd = W'($urandom);
      case ($urandom_range(0, 3))
        0: b = rnd;
        1: b = a;
        2: begin
          msk = W'(1) << $urandom_range(0, W - 1);
          b = a ^ msk;
        end
        default: begin
          msk = '1;
          msk = msk >> $urandom_range(1, W - 1);
          b = a ^ (rnd & msk);
        end
      endcase
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
